// File: rtl/ca_subchannel_receiver.sv
// Per-subchannel CA receiver: assembles 1/2-cycle CA commands, decodes them and flags protocol errors.
// Optional even-parity checking on each accepted word is enabled by defining CA_PARITY_EN.
module ca_subchannel_receiver #(
  parameter int CA_WIDTH       = 14,
  parameter int TIMEOUT_CYCLES = 4,
  parameter int COUNT_WIDTH    = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic [CA_WIDTH-1:0]     ca_in,
`ifdef CA_PARITY_EN
  input  logic                    ca_par_in,
`endif
  input  logic                    ca_valid_in,
  output logic                    ca_ready_out,
  output logic                    cmd_valid,
  input  logic                    cmd_ready,
  output logic [2:0]              cmd_type,
  output logic [2*CA_WIDTH-1:0]   cmd_addr,
  output logic [COUNT_WIDTH-1:0]  cmd_count,
  output logic [COUNT_WIDTH-1:0]  err_count,
  output logic                    err_pulse
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    CMD_ACT = 3'd0,
    CMD_RD  = 3'd1,
    CMD_WR  = 3'd2,
    CMD_MRW = 3'd3,
    CMD_PRE = 3'd4,
    CMD_REF = 3'd5
  } cmd_e;

  typedef enum logic {
    S_IDLE,
    S_WAIT_2ND
  } state_e;

  state_e                 state;
  cmd_e                   pend_type;
  logic [CA_WIDTH-1:0]    word0;
  logic [TMO_W-1:0]       tmo;

  logic                   accept;
  logic                   par_ok;
  logic [4:0]             opc;
  logic                   dec_one, dec_two, dec_nop;
  cmd_e                   dec_type;
  logic                   load;
  cmd_e                   ld_type;
  logic [2*CA_WIDTH-1:0]  ld_addr;
  logic                   err_evt;

  assign ca_ready_out = enable && !(cmd_valid && !cmd_ready);
  assign accept       = ca_valid_in && ca_ready_out;
  assign opc          = ca_in[4:0];

`ifdef CA_PARITY_EN
  assign par_ok = ~^{ca_in, ca_par_in};
`else
  assign par_ok = 1'b1;
`endif

  always_comb begin
    dec_one  = 1'b0;
    dec_two  = 1'b0;
    dec_nop  = 1'b0;
    dec_type = CMD_ACT;
    if (opc[1:0] == 2'b00) begin
      dec_two = 1'b1;
    end else begin
      case (opc)
        5'b11101: begin dec_two = 1'b1; dec_type = CMD_RD;  end
        5'b01101: begin dec_two = 1'b1; dec_type = CMD_WR;  end
        5'b00101: begin dec_two = 1'b1; dec_type = CMD_MRW; end
        5'b11011: begin dec_one = 1'b1; dec_type = CMD_PRE; end
        5'b10011: begin dec_one = 1'b1; dec_type = CMD_REF; end
        5'b11111: dec_nop = 1'b1;
        default:  ;
      endcase
    end
  end

  // A word accepted in WAIT_2ND always completes the command, even on the timeout cycle.
  always_comb begin
    load    = 1'b0;
    err_evt = 1'b0;
    ld_type = dec_type;
    ld_addr = {{CA_WIDTH{1'b0}}, ca_in};
    if (state == S_IDLE) begin
      if (accept) begin
        if (!par_ok)                   err_evt = 1'b1;
        else if (dec_one)              load    = 1'b1;
        else if (!dec_two && !dec_nop) err_evt = 1'b1;
      end
    end else begin
      ld_type = pend_type;
      ld_addr = {ca_in, word0};
      if (accept) begin
        if (!par_ok) err_evt = 1'b1;
        else         load    = 1'b1;
      end else if (enable && tmo == TMO_LAST) begin
        err_evt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      pend_type <= CMD_ACT;
      word0     <= '0;
      tmo       <= '0;
      cmd_valid <= 1'b0;
      cmd_type  <= '0;
      cmd_addr  <= '0;
      cmd_count <= '0;
      err_count <= '0;
      err_pulse <= 1'b0;
    end else begin
      err_pulse <= err_evt;
      if (err_evt && err_count != '1) err_count <= err_count + 1'b1;

      if (load) begin
        cmd_valid <= 1'b1;
        cmd_type  <= ld_type;
        cmd_addr  <= ld_addr;
        if (cmd_count != '1) cmd_count <= cmd_count + 1'b1;
      end else if (cmd_valid && cmd_ready) begin
        cmd_valid <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          if (accept && par_ok && dec_two) begin
            word0     <= ca_in;
            pend_type <= dec_type;
            tmo       <= '0;
            state     <= S_WAIT_2ND;
          end
        end
        S_WAIT_2ND: begin
          if (!enable || accept || tmo == TMO_LAST) state <= S_IDLE;
          else                                       tmo   <= tmo + 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ca_subchannel_receiver.sv
// Directed self-checking bench for ca_subchannel_receiver; parity cases run when CA_PARITY_EN is defined.
module tb_ca_subchannel_receiver;

  localparam int CAW = 14;
  localparam int CW  = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            enable;
  logic [CAW-1:0]  ca_in;
  logic            ca_valid_in;
  logic            cmd_ready;
  logic            par_flip;
  logic            ca_par;
  logic            ca_ready_out;
  logic            cmd_valid;
  logic [2:0]      cmd_type;
  logic [2*CAW-1:0] cmd_addr;
  logic [CW-1:0]   cmd_count;
  logic [CW-1:0]   err_count;
  logic            err_pulse;

  int checks = 0;
  int errors = 0;

  // Good parity by default; par_flip injects a parity error.
  assign ca_par = (^ca_in) ^ par_flip;

  ca_subchannel_receiver #(
    .CA_WIDTH       (CAW),
    .TIMEOUT_CYCLES (4),
    .COUNT_WIDTH    (CW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .ca_in        (ca_in),
`ifdef CA_PARITY_EN
    .ca_par_in    (ca_par),
`endif
    .ca_valid_in  (ca_valid_in),
    .ca_ready_out (ca_ready_out),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_type     (cmd_type),
    .cmd_addr     (cmd_addr),
    .cmd_count    (cmd_count),
    .err_count    (err_count),
    .err_pulse    (err_pulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [CAW-1:0] w);
    ca_in       = w;
    ca_valid_in = 1'b1;
    tick();
    ca_valid_in = 1'b0;
  endtask

  initial begin
    rst_n       = 1'b0;
    enable      = 1'b0;
    ca_in       = '0;
    ca_valid_in = 1'b0;
    cmd_ready   = 1'b1;
    par_flip    = 1'b0;
    repeat (3) tick();
    check("rst_valid", 32'(cmd_valid), 32'd0);
    check("rst_type",  32'(cmd_type),  32'd0);
    check("rst_addr",  32'(cmd_addr),  32'd0);
    check("rst_cmdcnt", 32'(cmd_count), 32'd0);
    check("rst_errcnt", 32'(err_count), 32'd0);
    check("rst_pulse", 32'(err_pulse), 32'd0);
    rst_n  = 1'b1;
    enable = 1'b1;
    tick();

    // REF single-cycle command
    put(14'h0013);
    check("ref_valid", 32'(cmd_valid), 32'd1);
    check("ref_type",  32'(cmd_type),  32'd5);
    check("ref_addr",  32'(cmd_addr),  32'h13);
    check("ref_cnt",   32'(cmd_count), 32'd1);
    tick();
    check("ref_drain", 32'(cmd_valid), 32'd0);

    // ACT two-cycle command
    put(14'h1230);
    check("act_w0_novalid", 32'(cmd_valid), 32'd0);
    put(14'h0ABC);
    check("act_valid", 32'(cmd_valid), 32'd1);
    check("act_type",  32'(cmd_type),  32'd0);
    check("act_addr",  32'(cmd_addr),  32'h02AF1230);
    check("act_cnt",   32'(cmd_count), 32'd2);
    tick();

    // WR first word then timeout after 4 idle cycles
    put(14'h000D);
    repeat (3) begin
      check("tmo_nopulse", 32'(err_pulse), 32'd0);
      tick();
    end
    check("tmo_nopulse3", 32'(err_pulse), 32'd0);
    tick();
    check("tmo_pulse",  32'(err_pulse), 32'd1);
    check("tmo_errcnt", 32'(err_count), 32'd1);
    check("tmo_novalid", 32'(cmd_valid), 32'd0);
    cmd_ready = 1'b0;
    put(14'h001B);
    check("tmo_pulse_end", 32'(err_pulse), 32'd0);
    check("pre_valid", 32'(cmd_valid), 32'd1);
    check("pre_type",  32'(cmd_type),  32'd4);
    check("pre_addr",  32'(cmd_addr),  32'h1B);
    check("pre_cnt",   32'(cmd_count), 32'd3);

    // Stall: REF waits behind a held PRE
    ca_in       = 14'h0013;
    ca_valid_in = 1'b1;
    #1;
    check("stall_ready", 32'(ca_ready_out), 32'd0);
    tick();
    check("stall_hold_valid", 32'(cmd_valid), 32'd1);
    check("stall_hold_type",  32'(cmd_type),  32'd4);
    check("stall_hold_cnt",   32'(cmd_count), 32'd3);
    cmd_ready = 1'b1;
    #1;
    check("unstall_ready", 32'(ca_ready_out), 32'd1);
    tick();
    ca_valid_in = 1'b0;
    check("b2b_valid", 32'(cmd_valid), 32'd1);
    check("b2b_type",  32'(cmd_type),  32'd5);
    check("b2b_cnt",   32'(cmd_count), 32'd4);
    tick();
    check("b2b_drain", 32'(cmd_valid), 32'd0);

    // Illegal opcode, then NOP
    put(14'h0017);
    check("ill_pulse",  32'(err_pulse), 32'd1);
    check("ill_errcnt", 32'(err_count), 32'd2);
    check("ill_novalid", 32'(cmd_valid), 32'd0);
    put(14'h001F);
    check("nop_pulse",  32'(err_pulse), 32'd0);
    check("nop_errcnt", 32'(err_count), 32'd2);
    check("nop_novalid", 32'(cmd_valid), 32'd0);
    check("nop_cnt",    32'(cmd_count), 32'd4);

    // RD: second word on the cycle the timeout would fire wins
    put(14'h001D);
    repeat (3) tick();
    put(14'h2155);
    check("edge_valid", 32'(cmd_valid), 32'd1);
    check("edge_type",  32'(cmd_type),  32'd1);
    check("edge_addr",  32'(cmd_addr),  {4'd0, 14'h2155, 14'h001D});
    check("edge_pulse", 32'(err_pulse), 32'd0);
    check("edge_errcnt", 32'(err_count), 32'd2);
    tick();

    // MRW aborted by enable drop, then PRE decodes cleanly
    put(14'h0005);
    enable = 1'b0;
    #1;
    check("dis_ready", 32'(ca_ready_out), 32'd0);
    tick();
    enable = 1'b1;
    put(14'h001B);
    check("abort_type",   32'(cmd_type),  32'd4);
    check("abort_addr",   32'(cmd_addr),  32'h1B);
    check("abort_errcnt", 32'(err_count), 32'd2);
    check("abort_cnt",    32'(cmd_count), 32'd6);
    tick();

`ifdef CA_PARITY_EN
    par_flip = 1'b1;
    put(14'h001D);
    par_flip = 1'b0;
    check("par_pulse",  32'(err_pulse), 32'd1);
    check("par_errcnt", 32'(err_count), 32'd3);
    check("par_novalid", 32'(cmd_valid), 32'd0);
    put(14'h1230);
    par_flip = 1'b1;
    put(14'h0ABC);
    par_flip = 1'b0;
    check("par_w1_errcnt", 32'(err_count), 32'd4);
    check("par_w1_novalid", 32'(cmd_valid), 32'd0);
    put(14'h0013);
    check("par_after_type", 32'(cmd_type), 32'd5);
    tick();
`endif

    // Async reset in WAIT_2ND loses word0
    put(14'h1230);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid",  32'(cmd_valid), 32'd0);
    check("arst_type",   32'(cmd_type),  32'd0);
    check("arst_addr",   32'(cmd_addr),  32'd0);
    check("arst_cmdcnt", 32'(cmd_count), 32'd0);
    check("arst_errcnt", 32'(err_count), 32'd0);
    check("arst_pulse",  32'(err_pulse), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    put(14'h0013);
    check("post_rst_type", 32'(cmd_type),  32'd5);
    check("post_rst_addr", 32'(cmd_addr),  32'h13);
    check("post_rst_cnt",  32'(cmd_count), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
